// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep sliced adder/subtractor with valid/ready handshake; carry ripples through registers.
// Define ADDER_SAT_EN to saturate signed overflow in the final stage.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;
`ifdef ADDER_SAT_EN
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif
  logic             w_adv;
  logic             r_v  [STAGES];
  logic             r_c  [STAGES];
  logic             r_cm [STAGES];
  logic [WIDTH-1:0] r_a  [STAGES];
  logic [WIDTH-1:0] r_b  [STAGES];
  logic [WIDTH-1:0] r_s  [STAGES];
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_cm[STAGES-1] ^ r_c[STAGES-1];
  genvar s;
  for (s = 0; s < STAGES; s++) begin : g_st
    logic [WIDTH-1:0] w_a, w_b, w_s, w_ns;
    logic [SLICE-1:0] w_sl;
    logic             w_ci, w_vi, w_co, w_cm;
    if (s == 0) begin : g_in
      assign w_a  = a;
      assign w_b  = sub ? ~b : b;
      assign w_ci = sub | cin;
      assign w_s  = '0;
      assign w_vi = in_valid;
    end else begin : g_mid
      assign w_a  = r_a[s-1];
      assign w_b  = r_b[s-1];
      assign w_ci = r_c[s-1];
      assign w_s  = r_s[s-1];
      assign w_vi = r_v[s-1];
    end
    assign {w_co, w_sl} = {1'b0, w_a[SLICE-1:0]} + {1'b0, w_b[SLICE-1:0]} + {{SLICE{1'b0}}, w_ci};
    // carry into this slice's top bit, recovered from its sum bit
    assign w_cm = w_a[SLICE-1] ^ w_b[SLICE-1] ^ w_sl[SLICE-1];
    // result slices shift down one slot per stage, the newest entering at the top
    always_comb begin
      w_ns = w_s >> SLICE;
      w_ns[WIDTH-SLICE +: SLICE] = w_sl;
`ifdef ADDER_SAT_EN
      if (s == STAGES-1 && (w_cm ^ w_co)) w_ns = w_a[SLICE-1] ? L_MIN : ~L_MIN;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[s]  <= 1'b0;
        r_c[s]  <= 1'b0;
        r_cm[s] <= 1'b0;
        r_a[s]  <= '0;
        r_b[s]  <= '0;
        r_s[s]  <= '0;
      end else if (w_adv) begin
        r_v[s]  <= w_vi;
        r_c[s]  <= w_co;
        r_cm[s] <= w_cm;
        r_a[s]  <= w_a >> SLICE;
        r_b[s]  <= w_b >> SLICE;
        r_s[s]  <= w_ns;
      end
    end
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor.
- Splits a WIDTH-bit operation into STAGES equal slices, one slice per register stage. The carry ripples between stages through registers.
- Replaces the fixed 4-bit ripple adder wherever operand width or clock rate would make a single ripple chain too long.
- Uses a valid/ready handshake on both sides, so it can sit directly between streaming datapath blocks.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH; slice width SLICE = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub=1, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation

- An operand set is accepted on a rising edge with in_valid && in_ready. A result is consumed on a rising edge with out_valid && out_ready.
- Effective inputs, latched in stage 1:
  - B' = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (k = 1..STAGES) adds slice k−1 (bits [k·SLICE−1 : (k−1)·SLICE]) of A and B' plus the registered carry from stage k−1 (c0 for stage 1).
- Each stage registers:
  - its result slice, plus all lower result slices from earlier stages;
  - the still-unprocessed upper slices of A and B';
  - its carry-out;
  - a valid bit.
- Final stage also registers the carry into the MSB. ovf and cout are derived from the final-stage registers.
- Pipeline control is a global advance enable: adv = !out_valid || out_ready.
  - When adv=1, all stages shift one position.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
- in_ready = adv, combinational from out_ready.
- Results leave strictly in acceptance order; none is dropped or duplicated.
- Arithmetic is modulo 2^WIDTH; cout and ovf are always reported.
- Reset (rst_n=0), asynchronous:
  - all valid bits → 0, so out_valid=0;
  - sum, cout, ovf → 0;
  - all data registers → 0.
  - in_ready reads 1 while in reset.
  - Operations in flight when reset asserts are discarded and never appear at the output.

## Timing

- Latency: an operation accepted at edge t drives out_valid=1 from edge t+STAGES−1 onward when there is no stall. For STAGES=1, the result is visible directly after the accepting edge.
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - in_ready=0;
  - sum, cout, ovf and out_valid hold stable.
- Simultaneous accept and consume in the same cycle is legal and required for full throughput.
- Outputs are registered; there is no combinational path from a, b, cin or sub to any output.
- The only combinational input-to-output path is out_ready → in_ready.

## Configuration

- ADDER_SAT_EN
  - Defined: the final stage saturates signed results. If ovf=1 and the operands' MSB was 0, sum = 0111…1; if ovf=1 and the operands' MSB was 1, sum = 1000…0. ovf still reads 1. cout is unaffected.
  - Undefined: sum wraps modulo 2^WIDTH; no saturation logic is instantiated.

## Test plan

Defaults WIDTH=16, STAGES=4 unless stated.

1. a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → 4 cycles later sum=0x0000, cout=1, ovf=0.
2. a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0.
3. a=0x7FFF, b=0x0001, sub=0 → ovf=1, cout=0. Without ADDER_SAT_EN: sum=0x8000. With ADDER_SAT_EN: sum=0x7FFF.
4. Eight back-to-back operations (a=i, b=0x1000·i, i=0..7), with out_ready=0 for 3 cycles mid-stream:
   - in_ready=0 and outputs stable during the stall;
   - all 8 sums appear in order with no loss or duplication.
5. Three operations in flight, then rst_n pulsed low for one cycle mid-clock:
   - out_valid=0 and sum=0 immediately;
   - after release, no stale results appear;
   - a new operation completes with 4-cycle latency.
6. WIDTH=4, STAGES=1, exhaustive a, b, cin, sub (1024 vectors) → 1-cycle latency; every result matches the 4-bit full-adder chain reference model (sum, cout) and the computed ovf.
